// File: rtl/gba_mem_pkg.sv
// Shared types and constants for the GBA memory bus controller.
// Region numbers follow the address select nibble of the CPU bus.
package gba_mem_pkg;

    typedef enum logic [1:0] {
        W_BYTE = 2'd0,
        W_HALF = 2'd1,
        W_WORD = 2'd2
    } width_t;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    localparam logic [3:0] REG_BIOS   = 4'd0;
    localparam logic [3:0] REG_IWRAM  = 4'd3;
    localparam logic [3:0] REG_VRAM   = 4'd6;
    localparam logic [3:0] REG_PAK_LO = 4'd8;
    localparam logic [3:0] REG_PAK_HI = 4'd13;

    // BIOS, IWRAM, VRAM plus the contiguous pak window.
    localparam logic [15:0] DEF_REGION_MAP =
        (16'd1 << REG_BIOS) | (16'd1 << REG_IWRAM) | (16'd1 << REG_VRAM) |
        ((16'd1 << (REG_PAK_HI + 4'd1)) - (16'd1 << REG_PAK_LO));

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane logic: strobes and write replication from width/addr[1:0],
// plus read alignment (word rotate, half/byte zero-extended lane extract).
module mem_lane_align
    import gba_mem_pkg::*;
(
    input  logic [1:0]  i_width,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata
);

    logic [63:0] w_dbl;
    logic [31:0] w_rot;

    assign w_dbl = {i_rdata, i_rdata};
    assign w_rot = w_dbl[{1'b0, i_addr_lo, 3'b000} +: 32];

    always_comb begin
        o_be    = 4'hF;
        o_wdata = i_wdata;
        o_rdata = w_rot;
        case (i_width)
            W_BYTE: begin
                o_be    = 4'b0001 << i_addr_lo;
                o_wdata = {4{i_wdata[7:0]}};
                o_rdata = {24'd0, i_rdata[{i_addr_lo, 3'b000} +: 8]};
            end
            W_HALF: begin
                o_be    = 4'b0011 << {i_addr_lo[1], 1'b0};
                o_wdata = {2{i_wdata[15:0]}};
                o_rdata = {16'd0, i_rdata[{i_addr_lo[1], 4'b0000} +: 16]};
            end
            default: begin
                o_be    = 4'hF;
                o_wdata = i_wdata;
                o_rdata = w_rot;
            end
        endcase
    end

endmodule

// File: rtl/gba_mem_ctrl.sv
// Wait-state-aware region controller between the CPU bus and on-chip memories.
// Latency 2+N cycles from accept (N = region wait states); one request in flight, req_ready only in IDLE.
module gba_mem_ctrl
    import gba_mem_pkg::*;
#(
    parameter int          DATA_W     = 32,
    parameter int          ADDR_W     = 32,
    parameter int          SEL_LSB    = 24,
    parameter logic [15:0] REGION_MAP = DEF_REGION_MAP,
    parameter int          WS_W       = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [1:0]          req_width,
    input  logic                req_read,
    input  logic                req_write,
    output logic                req_ready,
    output logic                rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    input  logic [16*WS_W-1:0]  ws_cfg,
    output logic [3:0]          mem_region,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [3:0]          mem_be,
    output logic                mem_re,
    output logic                mem_we,
    input  logic [16*32-1:0]    mem_rdata
);

    state_t              r_state, w_next;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [1:0]          r_width;
    logic [3:0]          r_region;
    logic [WS_W-1:0]     r_count;
    logic                r_read, r_write, r_err;

    logic                w_accept;
    logic [3:0]          w_sel;
    logic [WS_W-1:0]     w_ws;
    logic [3:0]          w_be;
    logic [31:0]         w_rdata_al;

    assign w_accept = (r_state == S_IDLE) && (req_read || req_write);
    assign w_sel    = req_addr[SEL_LSB +: 4];
    assign w_ws     = ws_cfg[w_sel*WS_W +: WS_W];

    mem_lane_align u_align (
        .i_width   (r_width),
        .i_addr_lo (r_addr[1:0]),
        .i_wdata   (r_wdata),
        .i_rdata   (mem_rdata[{r_region, 5'b00000} +: 32]),
        .o_be      (w_be),
        .o_wdata   (mem_wdata),
        .o_rdata   (w_rdata_al)
    );

    assign mem_region = r_region;
    assign mem_addr   = r_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Wait count is captured with the request so later ws_cfg writes cannot stretch it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr   <= '0;
            r_wdata  <= '0;
            r_width  <= '0;
            r_region <= '0;
            r_count  <= '0;
            r_read   <= 1'b0;
            r_write  <= 1'b0;
            r_err    <= 1'b0;
        end else if (w_accept) begin
            r_addr   <= req_addr;
            r_wdata  <= req_wdata;
            r_width  <= req_width;
            r_region <= w_sel;
            r_count  <= w_ws;
            r_read   <= req_read;
            r_write  <= req_write;
            r_err    <= (req_read && req_write) || !REGION_MAP[w_sel];
        end else if (r_state == S_WAIT) begin
            r_count  <= r_count - 1'b1;
        end
    end

    always_comb begin
        w_next    = r_state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_err   = 1'b0;
        rsp_rdata = '0;
        mem_re    = 1'b0;
        mem_we    = 1'b0;
        mem_be    = 4'd0;
        case (r_state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (w_accept) begin
                    w_next = (w_ws != '0) ? S_WAIT : S_ACCESS;
                end
            end
            S_WAIT: begin
                if (r_count == WS_W'(1)) begin
                    w_next = S_ACCESS;
                end
            end
            S_ACCESS: begin
                mem_re = r_read && !r_err;
                mem_we = r_write && !r_err;
                mem_be = r_err ? 4'd0 : w_be;
                w_next = S_RESP;
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                rsp_err   = r_err;
                rsp_rdata = (r_read && !r_err) ? w_rdata_al : '0;
                w_next    = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

endmodule

// File: doc/gba_mem_ctrl.md
# gba_mem_ctrl

Parametrised, wait-state-aware memory bus controller that replaces the combinational region decoder between the CPU bus and the on-chip memories (BIOS ROM, internal RAM, VRAM, pak RAM). It decodes a region from the address and applies a runtime-programmable wait-state count per region. It also generates byte-lane strobes for byte, half and word accesses, and aligns read data. A real ready/valid handshake replaces the constant `ok`.

## Interface
Parameters:
- DATA_W, 32, bus data width; must be 32 (4 byte lanes).
- ADDR_W, 32, bus address width.
- SEL_LSB, 24, LSB of the 4-bit region select field, addr[SEL_LSB+3:SEL_LSB].
- REGION_MAP, 16'h3F49, bit r set = region r mapped (0 BIOS, 3 IWRAM, 6 VRAM, 8–D pak).
- WS_W, 4, width of each per-region wait-state field.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- req_addr  in  ADDR_W  access address.
- req_wdata  in  32  write data, right-aligned.
- req_width  in  2  0 byte, 1 half, 2 word, 3 treated as word.
- req_read  in  1  read request.
- req_write  in  1  write request.
- req_ready  out  1  controller idle, request accepted this cycle if read|write.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  32  aligned read data, valid with rsp_valid.
- rsp_err  out  1  unmapped region or read&write both set, valid with rsp_valid.
- ws_cfg  in  16*WS_W  wait states for region r at [r*WS_W +: WS_W], sampled at accept.
- mem_region  out  4  latched region index.
- mem_addr  out  ADDR_W  latched address.
- mem_wdata  out  32  write data replicated across lanes.
- mem_be  out  4  byte enables.
- mem_re  out  1  one-cycle read strobe.
- mem_we  out  1  one-cycle write strobe.
- mem_rdata  in  16*32  per-region synchronous read data, region r at [r*32 +: 32], 1-cycle latency after mem_re.

## Operation
- FSM states: IDLE, WAIT, ACCESS, RESP. req_ready = (state==IDLE).
- IDLE: on read|write, latch addr/width/wdata/region and count = ws_cfg[region]. Go to WAIT if count≠0, else to ACCESS.
- WAIT: decrement count each cycle; at count==1, go to ACCESS.
- ACCESS: assert mem_re or mem_we for exactly one cycle. Unmapped region or read&write: no strobe, err latched. Go to RESP.
- RESP: rsp_valid=1. For reads, rsp_rdata = aligned mem_rdata[region]. Return to IDLE.
- Byte enables:
  - byte: 4'b0001<<addr[1:0]
  - half: 4'b0011<<{addr[1],1'b0}
  - word: 4'hF
- mem_wdata: byte replicated ×4, half ×2, word as is.
- Read alignment:
  - word: rotate right by 8*addr[1:0] (misaligned word rotation).
  - half: zero-extended lane {addr[1],0}.
  - byte: zero-extended lane addr[1:0].
- Writes return rsp_rdata=0. Error responses return rsp_rdata=0, rsp_err=1.

## Timing
- Accept at cycle T with wait states N: ACCESS at T+1+N, rsp_valid at T+2+N. Minimum latency is 2 cycles.
- Back-to-back: next request is accepted in the cycle after RESP (req_ready high again at T+3+N).
- Requests while req_ready=0 are ignored; the master must hold the request until accepted.
- ws_cfg changes after accept do not affect the access in flight.
- Reset values: state IDLE, req_ready=1, all other outputs 0. Reset asserted mid-access aborts it asynchronously: strobes drop, no rsp_valid.
- No combinational path from req_* to mem_* or rsp_*.

## Structure
- Package gba_mem_pkg holds:
  - width enum (W_BYTE, W_HALF, W_WORD)
  - FSM state enum
  - region index constants (REG_BIOS=0, REG_IWRAM=3, REG_VRAM=6, REG_PAK_LO=8, REG_PAK_HI=13)
  - default REGION_MAP
- Sub-module mem_lane_align is purely combinational: width+addr[1:0] → mem_be and replicated wdata; raw rdata → aligned rdata.
- The controller holds only the FSM, latches, counter and mux.

## Test plan
- Word read 0x0300_0004, ws_cfg[3]=0, IWRAM returns 0xDEADBEEF → mem_re at T+1, rsp_valid at T+2, rdata 0xDEADBEEF, err 0.
- Byte write 0x0600_0003, wdata 0x5A, ws_cfg[6]=0 → mem_be 4'b1000, mem_wdata 0x5A5A5A5A, mem_we one cycle.
- Misaligned word read 0x0800_0001, ws_cfg[8]=3, pak returns 0x11223344 → rsp_valid at T+5, rdata 0x44112233.
- Half read 0x0000_0002, BIOS returns 0xAABBCCDD → rdata 0x0000AABB.
- Read 0x0100_0000 (unmapped) → no mem_re, rsp_valid at T+2, err 1, rdata 0. Then read&write together → err 1.
- rst_n low during WAIT (ws=5) → mem_re never asserted, no rsp_valid, req_ready=1 after release.
